// File: rtl/vixen_fetch_engine.sv
// ---------------------------------------------------------------------------
// vixen_fetch_engine
//
// Multi-threaded instruction fetch front end. Keeps one fetch-block-aligned
// PC per SMT thread, picks a thread round-robin and sends one I-cache request
// at a time. Hit responses are pushed into a fetch queue that feeds decode.
// A redirect replaces a thread's PC and kills everything that thread still
// has in flight: its queued entries and its outstanding I-cache request.
//
// Ports
//   clk, rst_n         clock (rising edge) and asynchronous active-low reset
//   thread_active      per-thread fetch enable
//   redirect_valid     redirect/flush request for thread redirect_tid,
//   redirect_tid       new PC redirect_pc (aligned down to a fetch block)
//   redirect_pc
//   ic_req_valid       I-cache request: fetch block address and thread id,
//   ic_req_addr        accepted when ic_req_ready is high
//   ic_req_tid
//   ic_req_ready
//   ic_resp_valid      I-cache response for the outstanding request;
//   ic_resp_hit        a miss returns no data and the thread retries later
//   ic_resp_data
//   fq_out_valid       fetch-queue head (live entries only) to decode,
//   fq_out_data        popped when fq_out_ready is high
//   fq_out_pc
//   fq_out_tid
//   fq_out_ready
//   fq_count           occupied queue entries, killed ones included
// ---------------------------------------------------------------------------
module vixen_fetch_engine #(
    parameter int              NUM_THREADS = 2,
    parameter int              FETCH_BYTES = 16,
    parameter int              FQ_DEPTH    = 8,
    parameter int              PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    localparam int             TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int             DATA_W      = FETCH_BYTES * 8,
    localparam int             CNT_W       = $clog2(FQ_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_THREADS-1:0] thread_active,
    input  logic                   redirect_valid,
    input  logic [TID_W-1:0]       redirect_tid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   ic_req_valid,
    output logic [PC_W-1:0]        ic_req_addr,
    output logic [TID_W-1:0]       ic_req_tid,
    input  logic                   ic_req_ready,
    input  logic                   ic_resp_valid,
    input  logic                   ic_resp_hit,
    input  logic [DATA_W-1:0]      ic_resp_data,
    output logic                   fq_out_valid,
    output logic [DATA_W-1:0]      fq_out_data,
    output logic [PC_W-1:0]        fq_out_pc,
    output logic [TID_W-1:0]       fq_out_tid,
    input  logic                   fq_out_ready,
    output logic [CNT_W-1:0]       fq_count
);

    localparam int              PTR_W      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(FETCH_BYTES - 1));
    localparam logic [PC_W-1:0] PC_STEP    = PC_W'(FETCH_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FQ_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t state, state_next;

    // Requests are held off for the first cycle after reset release so that
    // the request port never depends combinationally on rst_n.
    logic run;

    logic [PC_W-1:0]  pc [NUM_THREADS];
    logic [TID_W-1:0] last_grant;

    // Outstanding request bookkeeping.
    logic [TID_W-1:0] out_tid;
    logic             out_killed;

    // A request that was offered but not accepted keeps its thread so the
    // request fields stay stable until the I-cache takes it.
    logic             hold_valid;
    logic [TID_W-1:0] hold_tid;

    // Fetch queue storage.
    logic [DATA_W-1:0] q_data [FQ_DEPTH];
    logic [PC_W-1:0]   q_pc   [FQ_DEPTH];
    logic [TID_W-1:0]  q_tid  [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] q_killed;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [NUM_THREADS-1:0] eligible;
    logic                   rr_found;
    logic [TID_W-1:0]       rr_tid;
    logic                   use_hold;
    logic [TID_W-1:0]       sel_tid;
    logic                   grant;
    logic                   resp_fire;
    logic                   resp_killed;
    logic                   push;
    logic                   pop;
    logic                   head_occ;
    logic                   head_killed;

    // A thread may be picked only if enabled, not being redirected right
    // now, and the queue has room for the block it would bring back.
    always_comb begin
        eligible = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            eligible[t] = thread_active[t] && (count < DEPTH_C) &&
                          !(redirect_valid && (redirect_tid == TID_W'(t)));
        end
    end

    // Round-robin search starting just after the last granted thread.
    always_comb begin
        logic [TID_W-1:0] cand;
        rr_found = 1'b0;
        rr_tid   = '0;
        cand     = '0;
        for (int off = 1; off <= NUM_THREADS; off++) begin
            cand = TID_W'((int'(last_grant) + off) % NUM_THREADS);
            if (!rr_found && eligible[cand]) begin
                rr_found = 1'b1;
                rr_tid   = cand;
            end
        end
    end

    // A held request is withdrawn if its own thread is redirected, since the
    // address it carries is no longer wanted.
    assign use_hold = hold_valid && !(redirect_valid && (redirect_tid == hold_tid));
    assign sel_tid  = use_hold ? hold_tid : rr_tid;

    assign ic_req_tid  = sel_tid;
    assign ic_req_addr = pc[sel_tid];
    assign grant       = ic_req_valid && ic_req_ready;

    // Response handling: a redirect of the outstanding thread in the same
    // cycle as its response kills the response just like an earlier one.
    assign resp_fire   = (state == WAIT) && ic_resp_valid;
    assign resp_killed = out_killed || (redirect_valid && (redirect_tid == out_tid));
    assign push        = resp_fire && ic_resp_hit && !resp_killed;

    // Killed heads are discarded one per cycle without being shown to decode.
    assign head_occ     = (count != '0);
    assign head_killed  = q_killed[head];
    assign fq_out_valid = head_occ && !head_killed;
    assign pop          = (fq_out_valid && fq_out_ready) || (head_occ && head_killed);

    assign fq_out_data = q_data[head];
    assign fq_out_pc   = q_pc[head];
    assign fq_out_tid  = q_tid[head];
    assign fq_count    = count;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and request valid. The queue slot for the outstanding
    // request is implicitly reserved: nothing is issued from WAIT, and a
    // request is only issued while the queue has a free slot.
    always_comb begin
        state_next   = state;
        ic_req_valid = 1'b0;
        case (state)
            IDLE: begin
                ic_req_valid = run && (use_hold || rr_found);
                if (ic_req_valid && ic_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (ic_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Arbitration, outstanding-request and PC state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            last_grant <= TID_W'(NUM_THREADS - 1);
            out_tid    <= '0;
            out_killed <= 1'b0;
            hold_valid <= 1'b0;
            hold_tid   <= '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc[t] <= RESET_PC & ALIGN_MASK;
            end
        end else begin
            run <= 1'b1;

            if (grant) begin
                last_grant <= sel_tid;
                out_tid    <= sel_tid;
                out_killed <= 1'b0;
            end else if ((state == WAIT) && redirect_valid && (redirect_tid == out_tid)) begin
                out_killed <= 1'b1;
            end

            hold_valid <= ic_req_valid && !ic_req_ready;
            if (ic_req_valid && !ic_req_ready) begin
                hold_tid <= sel_tid;
            end

            // Redirect wins over the increment from a hit of the same thread.
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redirect_valid && (redirect_tid == TID_W'(t))) begin
                    pc[t] <= redirect_pc & ALIGN_MASK;
                end else if (push && (out_tid == TID_W'(t))) begin
                    pc[t] <= pc[t] + PC_STEP;
                end
            end
        end
    end

    // Queue pointers, occupancy and kill bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            q_killed <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            // A head leaving this cycle is already gone, so marking it too is
            // harmless; the fresh push clears whatever was left in its slot.
            for (int i = 0; i < FQ_DEPTH; i++) begin
                if (redirect_valid && (q_tid[i] == redirect_tid)) begin
                    q_killed[i] <= 1'b1;
                end
            end
            if (push) begin
                q_killed[tail] <= 1'b0;
            end
        end
    end

    // Queue payload needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= ic_resp_data;
            q_pc[tail]   <= pc[out_tid];
            q_tid[tail]  <= out_tid;
        end
    end

endmodule

// File: tb/tb_vixen_fetch_engine.sv
// ---------------------------------------------------------------------------
// tb_vixen_fetch_engine
//
// Directed self-checking bench for vixen_fetch_engine with default
// parameters (2 threads, 16-byte blocks, 8-entry queue, 64-bit PC).
// ---------------------------------------------------------------------------
module tb_vixen_fetch_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   thread_active;
    logic         redirect_valid;
    logic [0:0]   redirect_tid;
    logic [63:0]  redirect_pc;
    logic         ic_req_valid;
    logic [63:0]  ic_req_addr;
    logic [0:0]   ic_req_tid;
    logic         ic_req_ready;
    logic         ic_resp_valid;
    logic         ic_resp_hit;
    logic [127:0] ic_resp_data;
    logic         fq_out_valid;
    logic [127:0] fq_out_data;
    logic [63:0]  fq_out_pc;
    logic [0:0]   fq_out_tid;
    logic         fq_out_ready;
    logic [3:0]   fq_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    vixen_fetch_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .thread_active  (thread_active),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .ic_req_valid   (ic_req_valid),
        .ic_req_addr    (ic_req_addr),
        .ic_req_tid     (ic_req_tid),
        .ic_req_ready   (ic_req_ready),
        .ic_resp_valid  (ic_resp_valid),
        .ic_resp_hit    (ic_resp_hit),
        .ic_resp_data   (ic_resp_data),
        .fq_out_valid   (fq_out_valid),
        .fq_out_data    (fq_out_data),
        .fq_out_pc      (fq_out_pc),
        .fq_out_tid     (fq_out_tid),
        .fq_out_ready   (fq_out_ready),
        .fq_count       (fq_count)
    );

    function automatic logic [127:0] mkdata(input logic [63:0] a);
        return {a ^ 64'hC0DE_0000_0000_BEEF, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        thread_active  = 2'b00;
        redirect_valid = 1'b0;
        redirect_tid   = 1'b0;
        redirect_pc    = '0;
        ic_req_ready   = 1'b0;
        ic_resp_valid  = 1'b0;
        ic_resp_hit    = 1'b0;
        ic_resp_data   = '0;
        fq_out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    // Acts as the I-cache for one request: wait (bounded) for a request,
    // accept it, then answer one cycle later with a hit or a miss.
    task automatic fetch_one(input logic hit, output logic ok,
                             output logic [0:0] tid, output logic [63:0] addr);
        ok   = 1'b0;
        tid  = 1'b0;
        addr = '1;
        #1;
        for (int i = 0; i < 6 && !ok; i++) begin
            if (ic_req_valid === 1'b1) ok = 1'b1;
            else step();
        end
        if (ok) begin
            tid          = ic_req_tid;
            addr         = ic_req_addr;
            ic_req_ready = 1'b1;
            step();
            ic_req_ready  = 1'b0;
            ic_resp_valid = 1'b1;
            ic_resp_hit   = hit;
            ic_resp_data  = mkdata(addr);
            step();
            ic_resp_valid = 1'b0;
            ic_resp_hit   = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        thread_active = 2'b11;
        rst_n = 1'b0;
        #3;
        checks++; if (ic_req_valid !== 1'b0) $display("[TB] FAIL reset_req_valid: got %0b want 0", ic_req_valid); else passes++;
        checks++; if (fq_out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0b want 0", fq_out_valid); else passes++;
        checks++; if (fq_count !== 4'd0) $display("[TB] FAIL reset_count: got %0d want 0", fq_count); else passes++;
        step();
        checks++; if (ic_req_valid !== 1'b0) $display("[TB] FAIL reset_held_req_valid: got %0b want 0", ic_req_valid); else passes++;
        thread_active = 2'b00;
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_round_robin();
        logic [0:0]  exp_tid [4];
        logic [63:0] exp_pc  [4];
        logic        ok;
        logic [0:0]  t;
        logic [63:0] a;
        exp_tid = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_pc  = '{64'h0, 64'h0, 64'h10, 64'h10};
        do_reset();
        thread_active = 2'b11;
        for (int i = 0; i < 4; i++) begin
            fetch_one(1'b1, ok, t, a);
            checks++; if (!ok || t !== exp_tid[i]) $display("[TB] FAIL rr_grant_tid[%0d]: got %0d (req seen %0b) want %0d", i, t, ok, exp_tid[i]); else passes++;
            checks++; if (a !== exp_pc[i]) $display("[TB] FAIL rr_grant_addr[%0d]: got %h want %h", i, a, exp_pc[i]); else passes++;
        end
        thread_active = 2'b00;
        #1;
        checks++; if (fq_count !== 4'd4) $display("[TB] FAIL rr_count: got %0d want 4", fq_count); else passes++;
        fq_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (fq_out_valid !== 1'b1 || fq_out_pc !== exp_pc[i] || fq_out_tid !== exp_tid[i] || fq_out_data !== mkdata(exp_pc[i]))
                $display("[TB] FAIL rr_queue[%0d]: got v=%0b pc=%h tid=%0d data=%h want v=1 pc=%h tid=%0d data=%h",
                         i, fq_out_valid, fq_out_pc, fq_out_tid, fq_out_data, exp_pc[i], exp_tid[i], mkdata(exp_pc[i]));
            else passes++;
            step();
        end
        fq_out_ready = 1'b0;
        checks++; if (fq_count !== 4'd0 || fq_out_valid !== 1'b0) $display("[TB] FAIL rr_drained: got count=%0d v=%0b want 0/0", fq_count, fq_out_valid); else passes++;
    endtask

    task automatic test_saturate();
        logic        ok;
        logic        all_ok;
        logic [0:0]  t;
        logic [63:0] a;
        do_reset();
        thread_active = 2'b11;
        all_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch_one(1'b1, ok, t, a);
            all_ok &= ok;
        end
        checks++; if (!all_ok || fq_count !== 4'd8) $display("[TB] FAIL sat_count: got %0d (reqs seen %0b) want 8", fq_count, all_ok); else passes++;
        checks++; if (ic_req_valid !== 1'b0) $display("[TB] FAIL sat_req_blocked: got %0b want 0", ic_req_valid); else passes++;
        step();
        step();
        checks++; if (ic_req_valid !== 1'b0 || fq_count !== 4'd8) $display("[TB] FAIL sat_stays_blocked: got v=%0b count=%0d want 0/8", ic_req_valid, fq_count); else passes++;
        fq_out_ready = 1'b1;
        step();
        fq_out_ready = 1'b0;
        fetch_one(1'b1, ok, t, a);
        checks++; if (!ok || t !== 1'b0 || a !== 64'h40) $display("[TB] FAIL sat_refill_req: got seen=%0b tid=%0d addr=%h want 1/0/40", ok, t, a); else passes++;
        checks++; if (fq_count !== 4'd8 || ic_req_valid !== 1'b0) $display("[TB] FAIL sat_refill_count: got count=%0d v=%0b want 8/0", fq_count, ic_req_valid); else passes++;
        step();
        step();
        checks++; if (ic_req_valid !== 1'b0) $display("[TB] FAIL sat_only_one_req: got %0b want 0", ic_req_valid); else passes++;
    endtask

    task automatic test_miss();
        logic        ok;
        logic [0:0]  t;
        logic [63:0] a;
        do_reset();
        redirect_valid = 1'b1;
        redirect_tid   = 1'b0;
        redirect_pc    = 64'h40;
        step();
        redirect_valid = 1'b0;
        thread_active  = 2'b11;
        fetch_one(1'b0, ok, t, a);
        checks++; if (!ok || t !== 1'b0 || a !== 64'h40) $display("[TB] FAIL miss_first_req: got seen=%0b tid=%0d addr=%h want 1/0/40", ok, t, a); else passes++;
        checks++; if (fq_count !== 4'd0) $display("[TB] FAIL miss_no_push: got %0d want 0", fq_count); else passes++;
        fetch_one(1'b1, ok, t, a);
        checks++; if (!ok || t !== 1'b1 || a !== 64'h0) $display("[TB] FAIL miss_other_thread: got seen=%0b tid=%0d addr=%h want 1/1/0", ok, t, a); else passes++;
        fetch_one(1'b1, ok, t, a);
        checks++; if (!ok || t !== 1'b0 || a !== 64'h40) $display("[TB] FAIL miss_retry: got seen=%0b tid=%0d addr=%h want 1/0/40", ok, t, a); else passes++;
        thread_active = 2'b00;
        #1;
        checks++; if (fq_count !== 4'd2 || fq_out_tid !== 1'b1 || fq_out_pc !== 64'h0) $display("[TB] FAIL miss_head0: got count=%0d tid=%0d pc=%h want 2/1/0", fq_count, fq_out_tid, fq_out_pc); else passes++;
        fq_out_ready = 1'b1;
        step();
        fq_out_ready = 1'b0;
        checks++; if (fq_out_valid !== 1'b1 || fq_out_tid !== 1'b0 || fq_out_pc !== 64'h40 || fq_out_data !== mkdata(64'h40))
            $display("[TB] FAIL miss_head1: got v=%0b tid=%0d pc=%h want 1/0/40", fq_out_valid, fq_out_tid, fq_out_pc); else passes++;
    endtask

    task automatic test_redirect_kill();
        logic        ok;
        logic [0:0]  t;
        logic [63:0] a;
        logic [63:0] exp_pc [3];
        exp_pc = '{64'h0, 64'h10, 64'h20};
        do_reset();
        thread_active = 2'b10;
        for (int i = 0; i < 3; i++) begin
            fetch_one(1'b1, ok, t, a);
            checks++; if (!ok || t !== 1'b1 || a !== exp_pc[i]) $display("[TB] FAIL kill_fill[%0d]: got seen=%0b tid=%0d addr=%h want 1/1/%h", i, ok, t, a, exp_pc[i]); else passes++;
        end
        thread_active  = 2'b00;
        redirect_valid = 1'b1;
        redirect_tid   = 1'b1;
        redirect_pc    = 64'h1234;
        step();
        redirect_valid = 1'b0;
        fq_out_ready   = 1'b1;
        #1;
        checks++; if (fq_out_valid !== 1'b0 || fq_count !== 4'd3) $display("[TB] FAIL kill_marked: got v=%0b count=%0d want 0/3", fq_out_valid, fq_count); else passes++;
        for (int i = 2; i >= 0; i--) begin
            step();
            checks++; if (fq_out_valid !== 1'b0 || fq_count !== 4'(i)) $display("[TB] FAIL kill_drop[%0d]: got v=%0b count=%0d want 0/%0d", i, fq_out_valid, fq_count, i); else passes++;
        end
        fq_out_ready  = 1'b0;
        thread_active = 2'b10;
        #1;
        checks++; if (ic_req_valid !== 1'b1 || ic_req_tid !== 1'b1 || ic_req_addr !== 64'h1230)
            $display("[TB] FAIL kill_new_req: got v=%0b tid=%0d addr=%h want 1/1/1230", ic_req_valid, ic_req_tid, ic_req_addr); else passes++;
        thread_active = 2'b00;
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        thread_active = 2'b01;
        #1;
        checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h0) $display("[TB] FAIL same_req: got v=%0b addr=%h want 1/0", ic_req_valid, ic_req_addr); else passes++;
        ic_req_ready = 1'b1;
        step();
        ic_req_ready   = 1'b0;
        ic_resp_valid  = 1'b1;
        ic_resp_hit    = 1'b1;
        ic_resp_data   = mkdata(64'h0);
        redirect_valid = 1'b1;
        redirect_tid   = 1'b0;
        redirect_pc    = 64'h800;
        step();
        ic_resp_valid  = 1'b0;
        ic_resp_hit    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        checks++; if (fq_count !== 4'd0 || fq_out_valid !== 1'b0) $display("[TB] FAIL same_no_push: got count=%0d v=%0b want 0/0", fq_count, fq_out_valid); else passes++;
        checks++; if (ic_req_valid !== 1'b1 || ic_req_tid !== 1'b0 || ic_req_addr !== 64'h800)
            $display("[TB] FAIL same_next_req: got v=%0b tid=%0d addr=%h want 1/0/800", ic_req_valid, ic_req_tid, ic_req_addr); else passes++;
        thread_active = 2'b00;
    endtask

    task automatic test_reset_midflight();
        logic        ok;
        logic        all_ok;
        logic [0:0]  t;
        logic [63:0] a;
        do_reset();
        thread_active = 2'b11;
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_one(1'b1, ok, t, a);
            all_ok &= ok;
        end
        #1;
        checks++; if (!all_ok || fq_count !== 4'd5 || ic_req_valid !== 1'b1) $display("[TB] FAIL mid_prefill: got count=%0d v=%0b seen=%0b want 5/1/1", fq_count, ic_req_valid, all_ok); else passes++;
        ic_req_ready = 1'b1;
        step();
        ic_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (fq_count !== 4'd0 || ic_req_valid !== 1'b0 || fq_out_valid !== 1'b0)
            $display("[TB] FAIL mid_reset_now: got count=%0d req=%0b out=%0b want 0/0/0", fq_count, ic_req_valid, fq_out_valid); else passes++;
        step();
        rst_n         = 1'b1;
        thread_active = 2'b00;
        ic_resp_valid = 1'b1;
        ic_resp_hit   = 1'b1;
        ic_resp_data  = mkdata(64'h20);
        step();
        ic_resp_valid = 1'b0;
        ic_resp_hit   = 1'b0;
        checks++; if (fq_count !== 4'd0 || fq_out_valid !== 1'b0) $display("[TB] FAIL mid_late_resp: got count=%0d v=%0b want 0/0", fq_count, fq_out_valid); else passes++;
        thread_active = 2'b11;
        #1;
        checks++; if (ic_req_valid !== 1'b1 || ic_req_tid !== 1'b0 || ic_req_addr !== 64'h0)
            $display("[TB] FAIL mid_restart_req: got v=%0b tid=%0d addr=%h want 1/0/0", ic_req_valid, ic_req_tid, ic_req_addr); else passes++;
        thread_active = 2'b00;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_saturate();
        test_miss();
        test_redirect_kill();
        test_redirect_same_cycle();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/vixen_fetch_engine.md
VIXEN_FETCH_ENGINE -- requirements
Module: vixen_fetch_engine

Interface
REQ-001 SHALL provide parameter NUM_THREADS, default 2, number of SMT threads (legal 1..4); TID_W = max(1, clog2(NUM_THREADS)).
REQ-002 SHALL provide parameter FETCH_BYTES, default 16, bytes per fetch block (power of 2, 4..64).
REQ-003 SHALL provide parameter FQ_DEPTH, default 8, fetch-queue entries (power of 2, 2..32).
REQ-004 SHALL provide parameter PC_W, default 64, PC width.
REQ-005 SHALL provide parameter RESET_PC, default 0, reset PC of every thread.
REQ-006 clk  input  1  clock; all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 thread_active  input  NUM_THREADS  per-thread fetch enable.
REQ-009 redirect_valid / redirect_tid / redirect_pc  input  1 / TID_W / PC_W  per-thread PC redirect and flush.
REQ-010 ic_req_valid / ic_req_addr / ic_req_tid  output  1 / PC_W / TID_W  I-cache request.
REQ-011 ic_req_ready  input  1  I-cache accepts request.
REQ-012 ic_resp_valid / ic_resp_hit / ic_resp_data  input  1 / 1 / FETCH_BYTES*8  I-cache response.
REQ-013 fq_out_valid / fq_out_data / fq_out_pc / fq_out_tid  output  1 / FETCH_BYTES*8 / PC_W / TID_W  fetch-queue head to decode.
REQ-014 fq_out_ready  input  1  decode accepts head.
REQ-015 fq_count  output  clog2(FQ_DEPTH)+1  occupied entries, killed entries included.

Function
REQ-016 SHALL hold one PC per thread, always FETCH_BYTES-aligned; ic_req_addr = selected thread PC.
REQ-017 FSM SHALL have states IDLE and WAIT; at most one request outstanding.
REQ-018 Thread eligible when: thread_active bit set, not redirect_tid of a redirect this cycle, and fq_count + 1 <= FQ_DEPTH.
REQ-019 In IDLE with any eligible thread, ic_req_valid SHALL be 1 and carry the round-robin winner: first eligible thread after the last granted, wrapping.
REQ-020 Grant on ic_req_valid && ic_req_ready; IDLE->WAIT; last-granted pointer updates; request fields SHALL stay stable while valid and not ready.
REQ-021 ic_resp_valid SHALL be ignored in IDLE; in WAIT it returns to IDLE that cycle (no new request that cycle).
REQ-022 Response hit, not killed: push {ic_resp_data, PC, tid} at tail; thread PC += FETCH_BYTES, wrapping modulo 2^PC_W.
REQ-023 Response miss: no push; thread PC unchanged; thread re-arbitrated normally.
REQ-024 Redirect: thread PC <= redirect_pc with low log2(FETCH_BYTES) bits cleared; all queued entries of that tid marked killed next cycle; outstanding request of that tid marked killed.
REQ-025 Killed response: no push, no PC update; redirect and response for same tid in same cycle -> response killed, PC = redirect target.
REQ-026 fq_out_valid = head occupied and not killed; pop on fq_out_valid && fq_out_ready.
REQ-027 Killed head SHALL be dropped automatically, one per cycle, without asserting fq_out_valid.
REQ-028 A head popped in the same cycle as a redirect of its tid SHALL complete normally.
REQ-029 Reservation: one FQ slot held while WAIT, so a hit never finds the queue full; push and pop in the same cycle SHALL leave fq_count unchanged.
REQ-030 No thread active: ic_req_valid = 0, FSM stays IDLE.

Reset
REQ-031 On rst_n low, immediately: FSM IDLE, all PCs = RESET_PC, queue empty, kill bits clear, last-granted = NUM_THREADS-1, ic_req_valid = 0, fq_out_valid = 0, fq_count = 0.
REQ-032 A response arriving after reset deassertion for a pre-reset request SHALL be ignored (FSM in IDLE).

Verification
REQ-033 Defaults, both active, ready=1, all hits, resp one cycle after grant -> grants alternate t0,t1,t0...; queue pcs 0x0(t0), 0x0(t1), 0x10(t0), 0x10(t1).
REQ-034 fq_out_ready=0, all hits -> fq_count saturates at 8, ic_req_valid then 0; one pop -> exactly one new request.
REQ-035 t0 miss then hit at PC 0x40 -> first request adds no entry; t1 granted next; t0 re-requests 0x40, pushes 0x40.
REQ-036 3 t1 entries queued, redirect t1 to 0x1234 -> 3 entries dropped over 3 cycles, fq_out_valid 0 for them; next t1 request addr 0x1230.
REQ-037 Redirect t0 to 0x800 in the same cycle as t0 hit response -> no push; next t0 request addr 0x800.
REQ-038 rst_n low while WAIT with 5 entries -> fq_count 0, ic_req_valid 0 at once; a late ic_resp_valid=1 after release pushes nothing.
